// File: rtl/tcb_lib_rvmodel_ctrl.sv
// RV model control block on TCB: signature bounds, halt, cycle counter and console FIFO.
// Optional timeout limit/flag at offset 0x28 is built when RVMODEL_CTRL_TIMEOUT_EN is defined.
module tcb_lib_rvmodel_ctrl #(
  parameter int unsigned DAW = 32,
  parameter int unsigned DDW = 32,
  parameter int unsigned CFD = 4,
  parameter int unsigned TMO = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tcb_vld,
  output logic             tcb_rdy,
  input  logic             tcb_wen,
  input  logic [DAW-1:0]   tcb_adr,
  input  logic [DDW/8-1:0] tcb_ben,
  input  logic [DDW-1:0]   tcb_wdt,
  output logic [DDW-1:0]   tcb_rdt,
  output logic             tcb_err,
  output logic             halt,
  output logic [DDW-2:0]   halt_code,
  output logic             timeout,
  output logic [DDW-1:0]   sig_begin,
  output logic [DDW-1:0]   sig_end,
  output logic [31:0]      cnt,
  output logic             con_vld,
  output logic [7:0]       con_dat,
  input  logic             con_rdy
);

  localparam int unsigned BEW = DDW / 8;
  localparam int unsigned FAW = $clog2(CFD);
  localparam int unsigned PW  = FAW + 1;

  localparam logic [5:0] OFS_SIGB = 6'h00;
  localparam logic [5:0] OFS_SIGE = 6'h08;
  localparam logic [5:0] OFS_HALT = 6'h10;
  localparam logic [5:0] OFS_CON  = 6'h18;
  localparam logic [5:0] OFS_CNT  = 6'h20;
  localparam logic [5:0] OFS_TMO  = 6'h28;

  localparam logic [DDW-1:0] TMO_RST = DDW'(TMO);

  logic [5:0]     ofs;
  logic           xfer;
  logic           wr_en;
  logic           acc_err;
  logic [DDW-1:0] rsp_dat;
  logic           halt_set;
  logic           tmo_hit;
  logic           cnt_run;

  logic [DDW-1:0] sig_begin_q, sig_begin_d;
  logic [DDW-1:0] sig_end_q, sig_end_d;
  logic           halt_q, halt_d;
  logic [DDW-2:0] halt_code_q, halt_code_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [DDW-1:0] rdt_q, rdt_d;
  logic           err_q, err_d;

  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [PW-1:0]  fill;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic [7:0]     fifo_mem [CFD];

  logic           unused_adr;

  function automatic logic [DDW-1:0] bmerge(input logic [DDW-1:0] old,
                                            input logic [DDW-1:0] wdt,
                                            input logic [BEW-1:0] ben);
    logic [DDW-1:0] res;
    res = old;
    for (int unsigned b = 0; b < BEW; b++) begin
      if (ben[b]) res[8*b +: 8] = wdt[8*b +: 8];
    end
    return res;
  endfunction

  assign ofs        = tcb_adr[5:0];
  assign unused_adr = ^tcb_adr[DAW-1:6];

  // FIFO status; the extra pointer bit separates full from empty
  assign fill       = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FAW] != rptr_q[FAW]) && (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);

  // Only a console write into a full FIFO is back-pressured
  assign tcb_rdy = !(tcb_vld && tcb_wen && (ofs == OFS_CON) && fifo_full);
  assign xfer    = tcb_vld && tcb_rdy;
  assign wr_en   = xfer && tcb_wen && !acc_err;

  assign halt_set = wr_en && (ofs == OFS_HALT) && tcb_ben[0] && tcb_wdt[0];
  assign push     = wr_en && (ofs == OFS_CON) && tcb_ben[0] && !fifo_full;
  assign pop      = !fifo_empty && con_rdy;

`ifdef RVMODEL_CTRL_TIMEOUT_EN
  logic [DDW-1:0] tmo_lim_q, tmo_lim_d;
  logic           timeout_q;

  // The counter stops on the limit value itself, so it reads back as the limit
  assign tmo_hit   = !halt_q && (tmo_lim_q != '0) && (DDW'(cnt_q) == tmo_lim_q);
  assign tmo_lim_d = (wr_en && (ofs == OFS_TMO)) ? bmerge(tmo_lim_q, tcb_wdt, tcb_ben) : tmo_lim_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_lim_q <= TMO_RST;
      timeout_q <= 1'b0;
    end else begin
      tmo_lim_q <= tmo_lim_d;
      timeout_q <= timeout_q || tmo_hit;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo = |TMO_RST;
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Register decode: read data and access error for the current request
  always_comb begin
    rsp_dat = '0;
    acc_err = 1'b0;
    case (ofs)
      OFS_SIGB: rsp_dat = sig_begin_q;
      OFS_SIGE: rsp_dat = sig_end_q;
      OFS_HALT: rsp_dat = {halt_code_q, halt_q};
      OFS_CON:  rsp_dat = DDW'(fill);
      OFS_CNT: begin
        rsp_dat = DDW'(cnt_q);
        acc_err = tcb_wen;
      end
`ifdef RVMODEL_CTRL_TIMEOUT_EN
      OFS_TMO:  rsp_dat = tmo_lim_q;
`endif
      default:  acc_err = 1'b1;
    endcase
    if (tcb_wen || acc_err) rsp_dat = '0;
  end

  assign cnt_run = !halt_q && !timeout && !tmo_hit;

  always_comb begin
    sig_begin_d = sig_begin_q;
    sig_end_d   = sig_end_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    rdt_d       = rdt_q;
    err_d       = err_q;
    if (wr_en && (ofs == OFS_SIGB)) sig_begin_d = bmerge(sig_begin_q, tcb_wdt, tcb_ben);
    if (wr_en && (ofs == OFS_SIGE)) sig_end_d = bmerge(sig_end_q, tcb_wdt, tcb_ben);
    if (halt_set) begin
      halt_d      = 1'b1;
      halt_code_d = tcb_wdt[DDW-1:1];
    end
    if (xfer) begin
      rdt_d = rsp_dat;
      err_d = acc_err;
    end
    cnt_d  = cnt_run ? cnt_q + 32'd1 : cnt_q;
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_begin_q <= '0;
      sig_end_q   <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      cnt_q       <= '0;
      rdt_q       <= '0;
      err_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      sig_begin_q <= sig_begin_d;
      sig_end_q   <= sig_end_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      cnt_q       <= cnt_d;
      rdt_q       <= rdt_d;
      err_q       <= err_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Storage needs no reset: con_dat is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[FAW-1:0]] <= tcb_wdt[7:0];
  end

  assign tcb_rdt   = rdt_q;
  assign tcb_err   = err_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign sig_begin = sig_begin_q;
  assign sig_end   = sig_end_q;
  assign cnt       = cnt_q;
  assign con_vld   = !fifo_empty;
  assign con_dat   = fifo_empty ? 8'h00 : fifo_mem[rptr_q[FAW-1:0]];

endmodule

// File: tb/tb_tcb_lib_rvmodel_ctrl.sv
// Scoreboard bench for tcb_lib_rvmodel_ctrl: directed scenarios plus random TCB traffic
// checked against a queue-based reference model (honours RVMODEL_CTRL_TIMEOUT_EN).
module tb_tcb_lib_rvmodel_ctrl;

  localparam int unsigned DAW = 32;
  localparam int unsigned DDW = 32;
  localparam int unsigned CFD = 4;
  localparam int unsigned TMO = 20000;
  localparam int unsigned BEW = DDW / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           tcb_vld;
  logic           tcb_rdy;
  logic           tcb_wen;
  logic [DAW-1:0] tcb_adr;
  logic [BEW-1:0] tcb_ben;
  logic [DDW-1:0] tcb_wdt;
  logic [DDW-1:0] tcb_rdt;
  logic           tcb_err;
  logic           halt;
  logic [DDW-2:0] halt_code;
  logic           timeout;
  logic [DDW-1:0] sig_begin;
  logic [DDW-1:0] sig_end;
  logic [31:0]    cnt;
  logic           con_vld;
  logic [7:0]     con_dat;
  logic           con_rdy;

  int checks = 0;
  int errors = 0;
  bit rnd_rdy = 1'b0;

  // Reference model state
  logic [DDW-1:0] m_sigb, m_sige, m_lim;
  logic           m_halt, m_to;
  logic [DDW-2:0] m_code;
  logic [31:0]    m_cnt;
  logic [7:0]     m_fifo [$];
  logic [DDW:0]   exp_q [$];
  bit             resp_due;

  tcb_lib_rvmodel_ctrl #(.DAW(DAW), .DDW(DDW), .CFD(CFD), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_ben(tcb_ben), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
    .halt(halt), .halt_code(halt_code), .timeout(timeout),
    .sig_begin(sig_begin), .sig_end(sig_end), .cnt(cnt),
    .con_vld(con_vld), .con_dat(con_dat), .con_rdy(con_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DDW-1:0] merge(input logic [DDW-1:0] old, input logic [DDW-1:0] wdt,
                                           input logic [BEW-1:0] ben);
    logic [DDW-1:0] r;
    r = old;
    for (int b = 0; b < int'(BEW); b++) if (ben[b]) r[8*b +: 8] = wdt[8*b +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    m_sigb = '0; m_sige = '0; m_lim = DDW'(TMO);
    m_halt = 1'b0; m_to = 1'b0; m_code = '0; m_cnt = '0;
    m_fifo.delete();
    exp_q.delete();
    resp_due = 1'b0;
  endfunction

  // Monitor + model: inputs change just after posedge, so at negedge they show the next edge's request
  always @(negedge clk) begin
    logic [DDW:0]   e;
    logic [5:0]     ofs;
    logic           exp_rdy, xf, err, at_lim, n_to;
    logic [DDW-1:0] rd;
    logic [31:0]    n_cnt;
    if (rst) begin
      chk("rst_halt", 64'(halt), 64'(0));
      chk("rst_halt_code", 64'(halt_code), 64'(0));
      chk("rst_timeout", 64'(timeout), 64'(0));
      chk("rst_cnt", 64'(cnt), 64'(0));
      chk("rst_sig_begin", 64'(sig_begin), 64'(0));
      chk("rst_sig_end", 64'(sig_end), 64'(0));
      chk("rst_rdt", 64'(tcb_rdt), 64'(0));
      chk("rst_err", 64'(tcb_err), 64'(0));
      chk("rst_con_vld", 64'(con_vld), 64'(0));
      chk("rst_con_dat", 64'(con_dat), 64'(0));
      model_reset();
    end else begin
      if (resp_due) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdt", 64'(tcb_rdt), 64'(e[DDW-1:0]));
          chk("rsp_err", 64'(tcb_err), 64'(e[DDW]));
        end
      end
      chk("halt", 64'(halt), 64'(m_halt));
      chk("halt_code", 64'(halt_code), 64'(m_code));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("cnt", 64'(cnt), 64'(m_cnt));
      chk("sig_begin", 64'(sig_begin), 64'(m_sigb));
      chk("sig_end", 64'(sig_end), 64'(m_sige));
      chk("con_vld", 64'(con_vld), 64'(m_fifo.size() != 0));

      ofs     = tcb_adr[5:0];
      exp_rdy = !(tcb_vld && tcb_wen && ofs == 6'h18 && m_fifo.size() == int'(CFD));
      chk("tcb_rdy", 64'(tcb_rdy), 64'(exp_rdy));
      xf       = tcb_vld && exp_rdy;
      resp_due = xf;

      at_lim = 1'b0;
`ifdef RVMODEL_CTRL_TIMEOUT_EN
      at_lim = !m_halt && (m_lim != '0) && (DDW'(m_cnt) == m_lim);
`endif
      n_to  = m_to || at_lim;
      n_cnt = (m_halt || m_to || at_lim) ? m_cnt : m_cnt + 32'd1;

      rd = '0; err = 1'b0;
      if (xf) begin
        case (ofs)
          6'h00: rd = m_sigb;
          6'h08: rd = m_sige;
          6'h10: rd = {m_code, m_halt};
          6'h18: rd = DDW'(m_fifo.size());
          6'h20: err = tcb_wen;
`ifdef RVMODEL_CTRL_TIMEOUT_EN
          6'h28: rd = m_lim;
`endif
          default: err = 1'b1;
        endcase
        if (ofs == 6'h20 && !tcb_wen) rd = DDW'(m_cnt);
        if (tcb_wen || err) rd = '0;
        exp_q.push_back({err, rd});
      end

      if (m_fifo.size() != 0) begin
        chk("con_dat", 64'(con_dat), 64'(m_fifo[0]));
        if (con_rdy) void'(m_fifo.pop_front());
      end

      if (xf && tcb_wen && !err) begin
        case (ofs)
          6'h00: m_sigb = merge(m_sigb, tcb_wdt, tcb_ben);
          6'h08: m_sige = merge(m_sige, tcb_wdt, tcb_ben);
          6'h10: if (tcb_ben[0] && tcb_wdt[0]) begin m_halt = 1'b1; m_code = tcb_wdt[DDW-1:1]; end
          6'h18: if (tcb_ben[0]) m_fifo.push_back(tcb_wdt[7:0]);
          6'h28: m_lim = merge(m_lim, tcb_wdt, tcb_ben);
          default: ;
        endcase
      end
      m_cnt = n_cnt;
      m_to  = n_to;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the request
  task automatic xfer(input logic wen, input logic [5:0] ofs, input logic [BEW-1:0] ben,
                      input logic [DDW-1:0] wdt, output int waited);
    tcb_vld = 1'b1; tcb_wen = wen; tcb_adr = {26'($urandom), ofs};
    tcb_ben = ben; tcb_wdt = wdt;
    waited = 0;
    @(negedge clk);
    while (!tcb_rdy && waited < 200) begin waited++; @(negedge clk); end
    if (waited >= 200) begin
      checks++; errors++;
      $display("FAIL handshake: tcb_rdy stuck low for %0d cycles, required high", waited);
    end
    @(posedge clk); #1;
    tcb_vld = 1'b0; tcb_wen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) con_rdy = 1'($urandom);
    end
  end

  initial begin
    #1_000_000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int w;
    int sel;
    logic [5:0]     r_ofs;
    logic [DDW-1:0] r_wdt;
    rst = 1'b1; tcb_vld = 1'b0; tcb_wen = 1'b0; tcb_adr = '0; tcb_ben = '0; tcb_wdt = '0;
    con_rdy = 1'b0;
    idle(2);
    rst = 1'b0;

    // Timeout limit right after reset
`ifdef RVMODEL_CTRL_TIMEOUT_EN
    xfer(1'b1, 6'h28, '1, 32'd10, w);
    idle(20);
    xfer(1'b0, 6'h28, '0, '0, w);
    idle(2);
    do_reset();
`else
    xfer(1'b0, 6'h28, '0, '0, w);
    xfer(1'b1, 6'h28, '1, 32'd10, w);
    idle(15);
`endif

    // Signature registers with byte enables
    xfer(1'b1, 6'h00, '1, 32'h1000_0200, w);
    xfer(1'b1, 6'h08, 4'h1, 32'h0000_00FF, w);
    xfer(1'b0, 6'h00, '0, '0, w);
    xfer(1'b0, 6'h08, '0, '0, w);
    xfer(1'b1, 6'h08, 4'b0100, 32'hAABB_CCDD, w);
    xfer(1'b0, 6'h08, '0, '0, w);

    // Unmapped read, write to read-only counter
    xfer(1'b0, 6'h30, '0, '0, w);
    xfer(1'b1, 6'h20, '1, 32'h1234_5678, w);
    xfer(1'b0, 6'h20, '0, '0, w);

    // Console back-pressure: fifth character stalls until the sink drains one
    rnd_rdy = 1'b0; con_rdy = 1'b0;
    for (int c = 0; c < 4; c++) xfer(1'b1, 6'h18, 4'h1, DDW'(8'h41 + c), w);
    xfer(1'b0, 6'h18, '0, '0, w);
    fork
      xfer(1'b1, 6'h18, 4'h1, 32'h45, w);
      begin idle(4); con_rdy = 1'b1; end
    join
    chk("con_full_stall", 64'(w >= 1), 64'(1));
    idle(8);
    xfer(1'b0, 6'h18, '0, '0, w);

    // Random traffic
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: r_ofs = 6'h00;
        1: r_ofs = 6'h08;
        2: r_ofs = 6'h10;
        3: r_ofs = 6'h18;
        4: r_ofs = 6'h20;
        5: r_ofs = 6'h28;
        6: r_ofs = 6'h30;
        default: r_ofs = 6'($urandom);
      endcase
      r_wdt = DDW'($urandom);
      if (r_ofs == 6'h10) r_wdt[0] = ($urandom_range(0, 15) == 0);
      xfer(1'($urandom), r_ofs, BEW'($urandom), r_wdt, w);
      idle(int'($urandom_range(0, 2)));
    end
    rnd_rdy = 1'b0;
    con_rdy = 1'b1;
    idle(6);

    // Sticky halt, then reset with a populated FIFO
    do_reset();
    con_rdy = 1'b0;
    xfer(1'b1, 6'h10, '1, 32'h5, w);
    idle(5);
    xfer(1'b1, 6'h10, '1, 32'h0, w);
    xfer(1'b0, 6'h10, '0, '0, w);
    for (int c = 0; c < 3; c++) xfer(1'b1, 6'h18, 4'h1, DDW'(8'h61 + c), w);
    idle(2);
    do_reset();
    xfer(1'b0, 6'h18, '0, '0, w);
    xfer(1'b0, 6'h10, '0, '0, w);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcb_lib_rvmodel_ctrl.md
TCB_LIB_RVMODEL_CTRL -- requirements
Module: tcb_lib_rvmodel_ctrl

Interface
REQ-001 Parameter DAW, default 32: TCB address width.
REQ-002 Parameter DDW, default 32: TCB data width, 32 or 64 only.
REQ-003 Parameter CFD, default 4: console FIFO depth, power of 2, minimum 2.
REQ-004 Parameter TMO, default 20000: timeout limit loaded at reset.
REQ-005 Port clk, input, 1: clock. Port rst, input, 1: reset. One clock; reset is asynchronous and active-high.
REQ-006 Port tcb_vld, input, 1: request valid. Port tcb_rdy, output, 1: request ready. A transfer occurs when both are high.
REQ-007 Request ports, all inputs: tcb_wen (1, write enable), tcb_adr (DAW, byte address), tcb_ben (DDW/8, byte enables), tcb_wdt (DDW, write data).
REQ-008 Response ports, all outputs: tcb_rdt (DDW, read data) and tcb_err (1, error).
REQ-009 Status outputs: halt (1), halt_code (DDW-1), timeout (1), sig_begin (DDW), sig_end (DDW), cnt (32, cycle counter).
REQ-010 Console stream: con_vld (output, 1), con_dat (output, 8), con_rdy (input, 1).

Function
REQ-011 Register map, decoded from tcb_adr[5:0]:
- 0x00 sig_begin, RW
- 0x08 sig_end, RW
- 0x10 halt/halt_code, RW
- 0x18 console, write pushes a character, read returns the FIFO fill level
- 0x20 cnt, RO
- 0x28 timeout limit, RW
REQ-012 Response delay is 1 cycle: tcb_rdt and tcb_err are valid in the cycle after the transfer and hold their value until the next transfer.
REQ-013 An access to an unmapped offset, or a write to 0x20, sets tcb_err=1 and returns tcb_rdt=0; register state does not change.
REQ-014 Writes to 0x00, 0x08 and 0x28 update only the bytes whose tcb_ben bit is set.
REQ-015 Write to 0x10 with tcb_ben[0]=1 and tcb_wdt[0]=1: halt goes high the next cycle and stays high (sticky); halt_code captures tcb_wdt[DDW-1:1].
REQ-016 Write to 0x10 with tcb_wdt[0]=0: no effect. Halt clears only on reset.
REQ-017 Reads of 0x10 return {halt_code, halt}.
REQ-018 cnt increments by 1 every cycle while halt=0 and timeout=0, and freezes once either is high. It wraps from 2^32-1 to 0.
REQ-019 Console FIFO:
- A write to 0x18 with tcb_ben[0]=1 pushes tcb_wdt[7:0].
- tcb_rdy=0 when tcb_vld=1, the access is a console write, and the FIFO is full.
- tcb_rdy=1 in all other cases.
- A pop in the same cycle as full does not raise tcb_rdy in that cycle.
REQ-020 Console output:
- con_vld is high whenever the FIFO is non-empty.
- con_dat is the oldest entry.
- A pop occurs when con_vld and con_rdy are both high.
- A simultaneous push and pop with the FIFO non-full and non-empty leaves the fill level unchanged.
REQ-021 Read of 0x18 returns the fill level (0..CFD), zero-extended to DDW.
REQ-022 Read pointer and write pointer wrap modulo CFD; full and empty are distinguished by an extra pointer bit.

Reset
REQ-023 On rst high the following take these values immediately:
- halt=0, halt_code=0, timeout=0, cnt=0
- sig_begin=0, sig_end=0
- tcb_rdt=0, tcb_err=0
- FIFO empty, con_vld=0, con_dat=0
- timeout limit=TMO
REQ-024 Reset asserted mid-transfer or with a non-empty FIFO discards all pending state; the first transfer is accepted in the cycle after rst is released.

Configuration
REQ-025 Macro RVMODEL_CTRL_TIMEOUT_EN.
- Defined: timeout goes high, sticky, in the cycle after cnt equals a non-zero limit while halt=0. A limit of 0 disables the timeout. Offset 0x28 is implemented.
- Not defined: timeout is tied to 0, and offset 0x28 is unmapped and responds with tcb_err=1.

Verification
REQ-026 Write 0x00=0x1000_0200 with ben=all, then write 0x08 with ben=0x1 and data 0xFF -> reads return 0x1000_0200 and 0x0000_00FF, err=0.
REQ-027 Write 0x10 with wdt=0x5 -> halt=1 the next cycle, halt_code=0x2, cnt frozen; a later write of 0x0 leaves halt=1.
REQ-028 With con_rdy=0, push 'A'..'E' with CFD=4 -> the 5th write stalls (tcb_rdy=0); raise con_rdy -> 'A' pops, the stalled 'E' is accepted, and the output order is A,B,C,D,E.
REQ-029 With RVMODEL_CTRL_TIMEOUT_EN defined, write 0x28=10 right after reset -> timeout=1 once cnt reaches 10 and cnt stays at 10. Without the macro, a read of 0x28 gives err=1 and timeout stays 0.
REQ-030 Read 0x30, then write 0x20 -> both respond err=1, rdt=0, and cnt is unaffected.
REQ-031 Assert rst while the FIFO holds 3 entries and halt=1 -> all outputs return to reset values, con_vld=0, and the fill-level read returns 0.
